// File: rtl/nonce_result_scanner.sv
// rtl/nonce_result_scanner.sv - minimum-hash and target scan over nonce results
//
// Purpose: reads NUM_NONCES consecutive 32-bit hash words starting at
// output_addr, tracks the smallest hash (lowest index wins ties) and whether
// any hash is strictly below target, then writes a two-word summary
// {best_hash} and {found, 25'b0, best_nonce} to result_addr / result_addr+1
// and pulses done for one cycle.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   start              begin a scan (sampled only when idle)
//   output_addr        base address of the hash words (latched at start)
//   result_addr        base address of the summary (latched at start)
//   target             difficulty target, unsigned (latched at start)
//   done               one-cycle completion pulse
//   found              some hash < target (valid from done onward)
//   best_nonce         index of the minimum hash
//   best_hash          minimum hash value
//   mem_clk            memory clock (same as clk)
//   mem_we             memory write enable
//   mem_addr           memory address
//   mem_write_data     memory write data
//   mem_read_data      memory read data, valid the cycle after the address

module nonce_result_scanner #(
  parameter int NUM_NONCES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] output_addr,
  input  logic [15:0] result_addr,
  input  logic [31:0] target,
  output logic        done,
  output logic        found,
  output logic [5:0]  best_nonce,
  output logic [31:0] best_hash,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [5:0] LAST = 6'(NUM_NONCES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_DRAIN, S_WR_HASH, S_WR_FLAGS, S_DONE
  } state_t;

  state_t      state_q;
  logic [5:0]  issue_q;
  logic [5:0]  recv_q;
  logic [15:0] result_addr_q;
  logic [31:0] target_q;
  logic [31:0] best_q;
  logic [5:0]  best_idx_q;
  logic        found_int_q;

  logic        done_q;
  logic        found_q;
  logic [5:0]  best_nonce_q;
  logic [31:0] best_hash_q;
  logic        mem_we_q;
  logic [15:0] mem_addr_q;
  logic [31:0] mem_write_data_q;

  logic        cap_en;
  logic [31:0] best_d;
  logic [5:0]  best_idx_d;
  logic        found_int_d;

  // Read data lags the address by one cycle: the first SCAN cycle has nothing
  // to capture, and DRAIN picks up the last word.
  always_comb begin
    cap_en      = ((state_q == S_SCAN) && (issue_q != 6'd0)) || (state_q == S_DRAIN);
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    found_int_d = found_int_q;
    if (cap_en) begin
      if (mem_read_data < best_q) begin
        best_d     = mem_read_data;
        best_idx_d = recv_q;
      end
      if (mem_read_data < target_q) begin
        found_int_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      issue_q          <= 6'd0;
      recv_q           <= 6'd0;
      result_addr_q    <= 16'd0;
      target_q         <= 32'd0;
      best_q           <= 32'd0;
      best_idx_q       <= 6'd0;
      found_int_q      <= 1'b0;
      done_q           <= 1'b0;
      found_q          <= 1'b0;
      best_nonce_q     <= 6'd0;
      best_hash_q      <= 32'd0;
      mem_we_q         <= 1'b0;
      mem_addr_q       <= 16'd0;
      mem_write_data_q <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            result_addr_q <= result_addr;
            target_q      <= target;
            best_q        <= 32'hFFFF_FFFF;
            best_idx_q    <= 6'd0;
            found_int_q   <= 1'b0;
            issue_q       <= 6'd0;
            recv_q        <= 6'd0;
            mem_addr_q    <= output_addr;
            state_q       <= S_SCAN;
          end
        end
        S_SCAN: begin
          best_q      <= best_d;
          best_idx_q  <= best_idx_d;
          found_int_q <= found_int_d;
          if (cap_en) begin
            recv_q <= recv_q + 6'd1;
          end
          if (issue_q == LAST) begin
            state_q <= S_DRAIN;
          end else begin
            issue_q    <= issue_q + 6'd1;
            mem_addr_q <= mem_addr_q + 16'd1;
          end
        end
        S_DRAIN: begin
          best_q           <= best_d;
          best_idx_q       <= best_idx_d;
          found_int_q      <= found_int_d;
          // Final word folds straight into the write data for the next cycle.
          mem_we_q         <= 1'b1;
          mem_addr_q       <= result_addr_q;
          mem_write_data_q <= best_d;
          state_q          <= S_WR_HASH;
        end
        S_WR_HASH: begin
          mem_addr_q       <= result_addr_q + 16'd1;
          mem_write_data_q <= {found_int_q, 25'b0, best_idx_q};
          state_q          <= S_WR_FLAGS;
        end
        S_WR_FLAGS: begin
          mem_we_q     <= 1'b0;
          done_q       <= 1'b1;
          found_q      <= found_int_q;
          best_nonce_q <= best_idx_q;
          best_hash_q  <= best_q;
          state_q      <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_clk        = clk;
  assign done           = done_q;
  assign found          = found_q;
  assign best_nonce     = best_nonce_q;
  assign best_hash      = best_hash_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_nonce_result_scanner.sv
// tb/tb_nonce_result_scanner.sv - directed self-checking bench for nonce_result_scanner

module tb_nonce_result_scanner;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [15:0] output_addr = 16'd0;
  logic [15:0] result_addr = 16'd0;
  logic [31:0] target = 32'd0;

  logic        done0, found0, mclk0, we0;
  logic [5:0]  nonce0;
  logic [31:0] hash0, wd0, rd0;
  logic [15:0] addr0;

  logic        done1, found1, mclk1, we1;
  logic [5:0]  nonce1;
  logic [31:0] hash1, wd1, rd1;
  logic [15:0] addr1;

  logic        tb_we = 1'b0;
  logic [15:0] tb_addr = 16'd0;
  logic [31:0] tb_wdata = 32'd0;

  logic [31:0] mem [0:65535];

  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  int we_cnt;
  logic [15:0] first_addr;
  logic got;

  always #5 clk = ~clk;

  nonce_result_scanner #(.NUM_NONCES(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0),
    .output_addr(output_addr), .result_addr(result_addr), .target(target),
    .done(done0), .found(found0), .best_nonce(nonce0), .best_hash(hash0),
    .mem_clk(mclk0), .mem_we(we0), .mem_addr(addr0),
    .mem_write_data(wd0), .mem_read_data(rd0)
  );

  nonce_result_scanner #(.NUM_NONCES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1),
    .output_addr(output_addr), .result_addr(result_addr), .target(target),
    .done(done1), .found(found1), .best_nonce(nonce1), .best_hash(hash1),
    .mem_clk(mclk1), .mem_we(we1), .mem_addr(addr1),
    .mem_write_data(wd1), .mem_read_data(rd1)
  );

  // Shared synchronous memory: one read port per DUT, registered read data.
  always @(posedge clk) begin
    rd0 <= mem[addr0];
    rd1 <= mem[addr1];
    if (we0) mem[addr0] <= wd0;
    if (we1) mem[addr1] <= wd1;
    if (tb_we) mem[tb_addr] <= tb_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1;
    tb_addr = a;
    tb_wdata = d;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  task automatic fill(input logic [15:0] base, input logic [31:0] v0, input int inc);
    for (int i = 0; i < 16; i++) poke(base + 16'(i), v0 + 32'(i * inc));
  endtask

  task automatic run(input bit sel, input logic [15:0] oa, input logic [15:0] ra,
                     input logic [31:0] tg, input bit pulse);
    @(negedge clk);
    output_addr = oa;
    result_addr = ra;
    target = tg;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    start1 = 1'b0;
    cyc = 0;
    we_cnt = 0;
    first_addr = 16'd0;
    got = 1'b0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (sel ? we1 : we0) we_cnt++;
      if (cyc == 1) first_addr = sel ? addr1 : addr0;
      if (pulse && cyc == 5) start0 = 1'b1;
      if (pulse && cyc == 6) start0 = 1'b0;
      if (sel ? done1 : done0) got = 1'b1;
    end
    check("done_seen", 32'(got), 32'd1);
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_done", 32'(done0), 32'd0);
    check("rst_found", 32'(found0), 32'd0);
    check("rst_nonce", 32'(nonce0), 32'd0);
    check("rst_hash", hash0, 32'd0);
    check("rst_we", 32'(we0), 32'd0);
    check("rst_addr", 32'(addr0), 32'd0);
    check("rst_wdata", wd0, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Descending data: minimum at the last index, nothing below target
    fill(16'h0020, 32'hF000_0000, -1);
    poke(16'h0040, 32'd0);
    poke(16'h0041, 32'hFFFF_FFFF);
    run(1'b0, 16'h0020, 16'h0040, 32'h1000_0000, 1'b0);
    check("desc_latency", 32'(cyc), 32'd20);
    check("desc_nonce", 32'(nonce0), 32'd15);
    check("desc_hash", hash0, 32'hEFFF_FFF1);
    check("desc_found", 32'(found0), 32'd0);
    check("desc_we_cycles", 32'(we_cnt), 32'd2);
    check("desc_mem40", mem[16'h0040], 32'hEFFF_FFF1);
    check("desc_mem41", mem[16'h0041], 32'h0000_000F);
    @(negedge clk);
    check("desc_done_one_cycle", 32'(done0), 32'd0);
    check("desc_hold_hash", hash0, 32'hEFFF_FFF1);

    // Ascending data: minimum at index 0, some below target
    fill(16'h0020, 32'h0000_0100, 1);
    run(1'b0, 16'h0020, 16'h0040, 32'h0000_0105, 1'b0);
    check("asc_nonce", 32'(nonce0), 32'd0);
    check("asc_hash", hash0, 32'h0000_0100);
    check("asc_found", 32'(found0), 32'd1);
    check("asc_mem41", mem[16'h0041], 32'h8000_0000);

    // Ties keep the lowest index; target comparison is strict
    fill(16'h0020, 32'h1234_5678, 0);
    run(1'b0, 16'h0020, 16'h0040, 32'h1234_5678, 1'b0);
    check("tie_nonce", 32'(nonce0), 32'd0);
    check("tie_found_eq", 32'(found0), 32'd0);
    check("tie_mem41", mem[16'h0041], 32'h0000_0000);
    run(1'b0, 16'h0020, 16'h0040, 32'h1234_5679, 1'b0);
    check("tie_found_above", 32'(found0), 32'd1);
    check("tie_mem41_b", mem[16'h0041], 32'h8000_0000);

    // All-ones data, zero target
    fill(16'h0020, 32'hFFFF_FFFF, 0);
    run(1'b0, 16'h0020, 16'h0040, 32'h0000_0000, 1'b0);
    check("ones_hash", hash0, 32'hFFFF_FFFF);
    check("ones_nonce", 32'(nonce0), 32'd0);
    check("ones_found", 32'(found0), 32'd0);
    check("ones_we_cycles", 32'(we_cnt), 32'd2);
    check("ones_mem40", mem[16'h0040], 32'hFFFF_FFFF);

    // Single-nonce instance reading at the top of the address space
    poke(16'hFFFF, 32'h0000_0055);
    poke(16'h0000, 32'h0000_0001);
    run(1'b1, 16'hFFFF, 16'h0080, 32'h0000_0056, 1'b0);
    check("one_latency", 32'(cyc), 32'd5);
    check("one_first_addr", 32'(first_addr), 32'h0000_FFFF);
    check("one_hash", hash1, 32'h0000_0055);
    check("one_found", 32'(found1), 32'd1);
    check("one_we_cycles", 32'(we_cnt), 32'd2);
    check("one_mem80", mem[16'h0080], 32'h0000_0055);
    check("one_mem81", mem[16'h0081], 32'h8000_0000);

    // Reset during scan cycle 7: outputs clear, no summary written
    fill(16'h0020, 32'hF000_0000, -1);
    run(1'b0, 16'h0020, 16'h0040, 32'h1000_0000, 1'b0);
    poke(16'h0040, 32'hDEAD_BEEF);
    poke(16'h0041, 32'hDEAD_BEEF);
    @(negedge clk);
    output_addr = 16'h0020;
    result_addr = 16'h0040;
    target = 32'h1000_0000;
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_hash", hash0, 32'd0);
    check("mid_rst_nonce", 32'(nonce0), 32'd0);
    check("mid_rst_we", 32'(we0), 32'd0);
    check("mid_rst_addr", 32'(addr0), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    check("mid_rst_done", 32'(done0), 32'd0);
    check("mid_rst_mem40", mem[16'h0040], 32'hDEAD_BEEF);
    check("mid_rst_mem41", mem[16'h0041], 32'hDEAD_BEEF);

    // Re-start after reset, with a stray start pulse during the scan
    run(1'b0, 16'h0020, 16'h0040, 32'h1000_0000, 1'b1);
    check("restart_latency", 32'(cyc), 32'd20);
    check("restart_hash", hash0, 32'hEFFF_FFF1);
    check("restart_nonce", 32'(nonce0), 32'd15);
    check("restart_mem40", mem[16'h0040], 32'hEFFF_FFF1);
    check("restart_mem41", mem[16'h0041], 32'h0000_000F);
    begin
      int extra;
      extra = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done0) extra++;
      end
      check("stray_start_ignored", 32'(extra), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
